// File: rtl/vpu_pkg.sv
// Vector unit shared types: lane/vector typedefs and the store FSM states.
// Shared by the vector register file, vector ALU and vector store unit.
package vpu_pkg;

  localparam int LANES  = 9;
  localparam int EW     = 9;
  localparam int RA_W   = 4;
  localparam int ADDR_W = 16;
  localparam int LW     = 4;

  typedef logic signed [EW-1:0] lane_t;
  typedef lane_t [LANES-1:0]    vec_t;
  typedef logic [LANES-1:0]     mask_t;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SEND,
    DONE
  } vst_state_t;

  // Lowest set lane at or above 'from'; LANES when none is left.
  function automatic logic [LW-1:0] next_set(
    input mask_t          m,
    input logic [LW-1:0]  from
  );
    logic [LW-1:0] r;
    r = LW'(LANES);
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i] && (LW'(i) >= from)) r = LW'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/vreg_store_unit.sv
// Vector store: snapshots one vector register, streams lanes to memory.
// Optional lane masking when VSTORE_MASK_EN is defined.
module vreg_store_unit
  import vpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [RA_W-1:0]   vreg,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
`ifdef VSTORE_MASK_EN
  input  mask_t             mask,
`endif
  output logic [RA_W-1:0]   ra,
  input  vec_t              rd,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output lane_t             mem_data,
  output logic [LW-1:0]     mem_lane,
  output logic              busy,
  output logic              done
);

  vst_state_t        state;
  vec_t              shadow;
  logic [LW-1:0]     lane;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] stride_q;

  logic [LW-1:0]     nxt;
  logic [LW-1:0]     first;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] first_addr;
  logic              none;
  logic              last;

`ifdef VSTORE_MASK_EN
  mask_t mask_q;

  // Skipped lanes still consume address space.
  assign nxt        = next_set(mask_q, lane + LW'(1));
  assign step       = ADDR_W'(nxt - lane) * stride_q;
  assign first      = next_set(mask_q, '0);
  assign first_addr = base_q + ADDR_W'(first) * stride_q;
  assign none       = (first == LW'(LANES));
`else
  assign nxt        = lane + LW'(1);
  assign step       = stride_q;
  assign first      = '0;
  assign first_addr = base_q;
  assign none       = 1'b0;
`endif

  assign last     = (nxt == LW'(LANES));
  assign mem_addr = cur_addr;
  assign mem_lane = lane;
  assign mem_data = shadow[lane];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ra        <= '0;
      base_q    <= '0;
      stride_q  <= '0;
      shadow    <= '0;
      lane      <= '0;
      cur_addr  <= '0;
      mem_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef VSTORE_MASK_EN
      mask_q    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            ra       <= vreg;
            base_q   <= base_addr;
            stride_q <= stride;
`ifdef VSTORE_MASK_EN
            mask_q   <= mask;
`endif
            busy     <= 1'b1;
            state    <= CAPTURE;
          end
        end
        CAPTURE: begin
          shadow   <= rd;
          lane     <= first;
          cur_addr <= first_addr;
          if (none) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            mem_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (mem_ready) begin
            if (last) begin
              mem_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              lane     <= nxt;
              cur_addr <= cur_addr + step;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vreg_store_unit.sv
// Directed bench for vreg_store_unit with a small register file model.
// Mask cases run only when VSTORE_MASK_EN is defined.
module tb_vreg_store_unit;
  import vpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [RA_W-1:0]   vreg = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] stride = '0;
`ifdef VSTORE_MASK_EN
  mask_t             mask = '1;
`endif
  logic [RA_W-1:0]   ra;
  vec_t              rd;
  logic              mem_valid;
  logic              mem_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  lane_t             mem_data;
  logic [LW-1:0]     mem_lane;
  logic              busy;
  logic              done;

  vec_t rf [16];
  assign rd = rf[ra];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vreg_store_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .vreg      (vreg),
    .base_addr (base_addr),
    .stride    (stride),
`ifdef VSTORE_MASK_EN
    .mask      (mask),
`endif
    .ra        (ra),
    .rd        (rd),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_lane  (mem_lane),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // rmode 0: ready tied high; 1: ready pattern 1,0,0,1.
  task automatic run(input string tag, input logic [RA_W-1:0] v,
                     input logic [15:0] b, input logic [15:0] s,
                     input mask_t m, input int rmode,
                     input int abort_c, input bit poke);
    lane_t         ed [LANES];
    logic [15:0]   ea [LANES];
    logic [LW-1:0] el [LANES];
    logic [15:0]   a;
    vec_t          snap;
    int nb = 0, k = 0, ndone = 0, dcyc = -1, fcyc = -1;
    bit aborted = 0;
    snap = rf[v];
    a = b;
    for (int l = 0; l < LANES; l++) begin
      if (m[l]) begin
        ea[nb] = a;
        ed[nb] = snap[l];
        el[nb] = LW'(l);
        nb++;
      end
      a = a + s;
    end
    @(negedge clk);
    vreg = v; base_addr = b; stride = s; start = 1'b1;
`ifdef VSTORE_MASK_EN
    mask = m;
`endif
    @(negedge clk);
    start = 1'b0; vreg = '1; base_addr = '1; stride = '1;
    check({tag, "_cap_busy"}, 32'(busy), 32'd1);
    check({tag, "_cap_valid"}, 32'(mem_valid), 32'd0);
    for (int c = 0; c < 80; c++) begin
      if (c > 0) @(negedge clk);
      if (abort_c == c) begin
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_valid"}, 32'(mem_valid), 32'd0);
        check({tag, "_rst_busy"}, 32'(busy), 32'd0);
        check({tag, "_rst_ra"}, 32'(ra), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1;
        break;
      end
      if (poke && c == 2) begin
        for (int l = 0; l < LANES; l++) rf[v][l] = lane_t'(7);
        start = 1'b1;
      end
      if (poke && c == 3) start = 1'b0;
      if (mem_valid) begin
        if (fcyc < 0) fcyc = c;
        if (k < nb) begin
          check({tag, "_addr"}, 32'(mem_addr), 32'(ea[k]));
          check({tag, "_data"}, 32'(mem_data), 32'(ed[k]));
          check({tag, "_lane"}, 32'(mem_lane), 32'(el[k]));
        end else begin
          check({tag, "_extra_beat"}, 32'(k), 32'(nb));
        end
      end
      if (done) begin
        ndone++;
        if (dcyc < 0) dcyc = c;
      end
      mem_ready = (rmode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      if (mem_valid && mem_ready) k++;
      if (dcyc >= 0 && c >= dcyc + 3) break;
    end
    mem_ready = 1'b0;
    if (aborted) begin
      repeat (3) begin
        @(negedge clk);
        if (done) ndone++;
      end
      check({tag, "_abort_done"}, 32'(ndone), 32'd0);
      check({tag, "_abort_busy"}, 32'(busy), 32'd0);
    end else begin
      check({tag, "_beats"}, 32'(k), 32'(nb));
      check({tag, "_ndone"}, 32'(ndone), 32'd1);
      check({tag, "_end_busy"}, 32'(busy), 32'd0);
      check({tag, "_end_valid"}, 32'(mem_valid), 32'd0);
      if (rmode == 0) begin
        check({tag, "_first"}, 32'(fcyc), (nb == 0) ? 32'hFFFFFFFF : 32'd1);
        check({tag, "_dcyc"}, 32'(dcyc), (nb == 0) ? 32'd1 : 32'(nb + 1));
      end
    end
    rf[v] = snap;
  endtask

  initial begin
    for (int r = 0; r < 16; r++) rf[r] = '0;
    for (int l = 0; l < LANES; l++) begin
      rf[2][l] = lane_t'(l + 1);
      rf[5][l] = lane_t'(-5);
    end
    repeat (2) @(negedge clk);
    check("rst_ra", 32'(ra), 32'd0);
    check("rst_valid", 32'(mem_valid), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(mem_data), 32'd0);
    check("rst_lane", 32'(mem_lane), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    run("base", 4'd2, 16'h0100, 16'd1, '1, 0, -1, 1'b0);
    run("stall", 4'd2, 16'h0100, 16'd1, '1, 1, -1, 1'b0);
    run("wrap", 4'd5, 16'hFFFE, 16'd2, '1, 0, -1, 1'b0);
    run("poke", 4'd2, 16'h0100, 16'd1, '1, 0, -1, 1'b1);
    run("abort", 4'd2, 16'h0100, 16'd1, '1, 0, 4, 1'b0);
    run("after", 4'd2, 16'h0200, 16'd3, '1, 0, -1, 1'b0);
`ifdef VSTORE_MASK_EN
    run("mask", 4'd2, 16'h0010, 16'd4, 9'b000010001, 0, -1, 1'b0);
    run("mask0", 4'd2, 16'h0010, 16'd4, '0, 0, -1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
